// File: rtl/fifo_pkg.sv
// Shared FIFO types: status flag bundle and pointer-width helper, common to the
// single-clock and dual-clock FIFOs.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status;

  // Smallest w with 2**w >= depth.
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags and
// overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = ptr_width(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wt_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_prog: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_prog: AE_THRESH must be below DEPTH");
  end

  localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_LVL   = (PTR_WIDTH + 1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_LVL   = (PTR_WIDTH + 1)'(AE_THRESH);

  logic [PTR_WIDTH-1:0]  wt_pt, rd_pt;
  logic [PTR_WIDTH:0]    cnt_q;
  logic                  overflow_q, underflow_q;
  logic                  wa, ra;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_status            status;

  // Accepts use the registered flags, so a read frees no slot for a same-edge write.
  assign wa = wt_en & ~status.full;
  assign ra = rd_en & ~status.empty;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(PTR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wa),
    .waddr(wt_pt),
    .wdata(wdata),
    .raddr(rd_pt),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wt_pt       <= '0;
      rd_pt       <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wa) wt_pt <= wt_pt + 1'b1;
      if (ra) rd_pt <= rd_pt + 1'b1;
      if (wa && !ra)      cnt_q <= cnt_q + 1'b1;
      else if (ra && !wa) cnt_q <= cnt_q - 1'b1;
      overflow_q  <= wt_en & status.full;
      underflow_q <= rd_en & status.empty;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata = mem_rdata;
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata_q <= '0;
    else if (ra) rdata_q <= mem_rdata;
  end

  assign rdata = rdata_q;
`endif

  always_comb begin
    status              = '0;
    status.full         = (cnt_q == FULL_LVL);
    status.empty        = (cnt_q == '0);
    status.almost_full  = (cnt_q >= AF_LVL);
    status.almost_empty = (cnt_q <= AE_LVL);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = cnt_q;

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO; successor to the team's dual-clock FIFO for same-domain buffering.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and correct simultaneous read/write when full or empty.
- Overflow/underflow reporting is retained.
- Sits between producer and consumer datapaths in one clock domain. No synchroniser logic.

Parameters:
DATA_WIDTH, 8, width of wdata/rdata
DEPTH, 16, number of entries; power of 2, >= 2
PTR_WIDTH, $clog2(DEPTH), read/write pointer width
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
wt_en  input  1  write request
wdata  input  DATA_WIDTH  write data
rd_en  input  1  read request
rdata  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write attempted while full
underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release): wt_pt=0, rd_pt=0, count=0, rdata=0, overflow=0, underflow=0 → empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- Reset mid-operation discards all contents. The first edge after release behaves as after power-up.
- Write accept: wa = wt_en & !full. Read accept: ra = rd_en & !empty. Both are evaluated on pre-edge state.
- Write accept: mem[wt_pt] <= wdata; wt_pt increments modulo DEPTH (natural wrap at DEPTH-1 → 0).
- Read accept (standard mode): rdata <= mem[rd_pt]; rd_pt increments modulo DEPTH. Latency is 1 cycle: data is valid on the edge after the rd_en sample.
- count update: +1 on wa & !ra; -1 on ra & !wa; unchanged otherwise.
- Simultaneous wt_en & rd_en:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow=1. No write-through of the slot being freed.
  - Empty: write accepted, read rejected, underflow=1, rdata holds.
- overflow/underflow: registered, high for exactly one cycle per offending request, cleared the next cycle if no new offence.
- Flags: full, empty, almost_full and almost_empty are pure decodes of the registered count. No combinational path from wt_en/rd_en to any output.
- rdata holds its last value when no read is accepted.
- Elaboration error if DEPTH is not a power of 2, AF_THRESH > DEPTH, or AE_THRESH >= DEPTH.

Optional Feature:
Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through): rdata = mem[rd_pt] continuously while !empty, and the head word is visible in the same cycle empty deasserts. rd_en pops the head; the next word appears after the edge. rdata is don't-care while empty. Latency from write to visible rdata is 1 cycle.
- Undefined: standard registered-read behaviour as above.
- Flags, count and overflow/underflow are identical in both modes.

Decomposition:
- Package fifo_pkg: fifo_status struct (full, empty, almost_full, almost_empty, overflow, underflow); ptr_width(depth) constant function; shared with the dual-clock FIFO for status reporting.
- One sub-module, fifo_mem: DEPTH×DATA_WIDTH array with one synchronous write port and one asynchronous read port. The top level owns pointers, count, flags and the rdata register.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → count=0, empty=1, almost_empty=1, full=0, rdata=0. Assert rst=0 mid-cycle → outputs reset immediately, without waiting for an edge.
- Fill: 17 writes of 0x01..0x11 (DEPTH=16) → full=1 after the 16th write. The 17th write gives overflow=1 for one cycle and count stays 16. almost_full rises when count reaches 14.
- Drain and wrap: after fill, 16 reads → rdata sequence 0x01..0x10 one cycle after each rd_en. A 17th read gives underflow=1 and rdata holds 0x10. Refill 20 words and drain to check pointer wrap.
- Simultaneous at boundaries:
  - Full + wt_en + rd_en → read occurs, overflow=1, count=15.
  - Empty + wt_en + rd_en → write occurs, underflow=1, count=1.
- Steady stream: count=5, wt_en=rd_en=1 for 50 cycles with an incrementing pattern → count stays 5, data in order, no flags.
- FWFT build: write 0xA5 into an empty FIFO → next cycle empty=0 and rdata=0xA5 with no rd_en. rd_en=1 → empty=1 the next cycle.
